debounce_chaves: RTL and testbench
==================================

Name: debounce_chaves

Overview:
- Input-conditioning stage placed directly upstream of the switch consumers (ones-counter/adders, LED matrix driver, display decoder path).
- Synchronises the 8 raw board switches into the `clock` domain and filters mechanical bounce per bit.
- Downstream blocks take `chaves_db` in place of the raw switch bus.
- Also emits one-cycle change strobes, so later logic can react to edits without polling.

Parameters:
- WIDTH, 8, number of switch bits filtered.
- STABLE_CYCLES, 500000, number of consecutive cycles a new level must persist before it is accepted (10 ms at 50 MHz). Legal range is 1 to 2^CNT_W.
- CNT_W, 20, width of each per-bit stability counter. Must satisfy STABLE_CYCLES-1 < 2^CNT_W.
- RESET_VAL, 0 (WIDTH bits), value loaded into `chaves_db` on reset.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- chaves  input  WIDTH  raw, asynchronous switch levels from the board.
- chaves_db  output  WIDTH  debounced, registered switch levels.
- mudou  output  WIDTH  per-bit one-cycle strobe; high in the cycle after `chaves_db[i]` changes.
- alguma_mudou  output  1  OR of all `mudou` bits, registered with `mudou` (same cycle).

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - sync stage 1 and sync stage 2 clear to 0;
  - all counters clear to 0;
  - `chaves_db` = RESET_VAL;
  - `mudou` = 0 and `alguma_mudou` = 0.
- Assertion of reset mid-count abandons any pending change. On release, filtering restarts from the cleared state.
- Synchroniser: 2-FF chain per bit. sync1 <= chaves; sync2 <= sync1. No logic is allowed between the two flops.
- Per-bit filter; each bit is fully independent, with no shared counter. At every rising edge:
  - If sync2[i] == chaves_db[i]: cnt[i] <= 0, and `chaves_db[i]` holds.
  - Else if cnt[i] == STABLE_CYCLES-1: chaves_db[i] <= sync2[i] and cnt[i] <= 0. In the same edge mudou[i] <= 1.
  - Else: cnt[i] <= cnt[i]+1.
- `mudou[i]` is 0 on every edge where `chaves_db[i]` does not change. It is a strict single-cycle pulse.
- Latency: number the first rising edge that samples a new steady level into sync1 as edge 1. `chaves_db[i]` updates, and `mudou[i]` rises, on edge STABLE_CYCLES+2.
  - With STABLE_CYCLES=1 this is edge 3 (synchroniser latency only).
- Bounce: any return of sync2[i] to the `chaves_db[i]` value before acceptance zeroes cnt[i]. The full STABLE_CYCLES window must then be re-served.
- Counter width: cnt[i] never exceeds STABLE_CYCLES-1 and never wraps.
- Simultaneous events:
  - Several bits may be accepted on the same edge. `mudou` then shows all of them, and `alguma_mudou` = 1 for exactly one cycle.
  - Bits changing at different times produce independent pulses.
- A level held for exactly STABLE_CYCLES sync2 cycles is accepted. A level held for STABLE_CYCLES-1 cycles is rejected.
- Outputs are purely registered; there is no combinational path from `chaves` to any output.

Test Plan (STABLE_CYCLES=4, RESET_VAL=8'h00):
- Reset and idle: assert reset with chaves=8'hFF, release it, then wait 1 cycle. Required: chaves_db=8'h00 and mudou=0. Counting from the first sampling edge after release, bit i accepted on edge 6: chaves_db=8'hFF, mudou=8'hFF, alguma_mudou=1 for exactly 1 cycle.
- Clean change: chaves 8'h00 -> 8'h05, held. Required: chaves_db=8'h05 on edge 6 after the first sampling edge, mudou=8'h05 for 1 cycle; no earlier change.
- Bounce rejection: toggle bit 3 as 1 for 3 cycles, then 0 for 1 cycle, then 1, held. Required: no change during the bounce; chaves_db[3]=1 exactly 6 edges after the final rising sample; a single mudou[3] pulse.
- Threshold: bit 7 high for exactly 4 sync2 cycles -> accepted. Bit 6 high for exactly 3 cycles -> chaves_db[6] stays 0 and mudou[6] stays 0.
- Independent bits: bit 0 rises at edge 1 and bit 1 rises at edge 3. Required: mudou=8'h01 at edge 6 and mudou=8'h02 at edge 8; alguma_mudou pulses twice.
- Reset mid-operation: bit 2 rises, then reset is asserted asynchronously (between edges) after cnt[2]=2. Required: immediate chaves_db=8'h00 and mudou=0. After release with bit 2 still high, acceptance takes the full 6 edges; the old count is not resumed.

Source files
------------

// File: rtl/debounce_chaves.sv
// debounce_chaves
// Takes the raw board switches through a two-flop synchroniser into the
// clock domain, then filters each bit on its own. A bit of chaves_db only
// takes a new level after that level has been seen on the synchroniser
// output for STABLE_CYCLES cycles in a row.
// mudou pulses for one cycle on each accepted change, and alguma_mudou is
// the OR of mudou, registered in the same cycle.
// All outputs come straight from flops.
module debounce_chaves #(
    parameter int               WIDTH         = 8,
    parameter int               STABLE_CYCLES = 500000,
    parameter int               CNT_W         = 20,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] chaves,
    output logic [WIDTH-1:0] chaves_db,
    output logic [WIDTH-1:0] mudou,
    output logic             alguma_mudou
);

    // Count value reached on the last cycle of the stability window.
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] db_next;
    logic [WIDTH-1:0] mudou_next;

    // Two-flop synchroniser with nothing between the flops, so metastability
    // has a full cycle to resolve.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= chaves;
            sync2 <= sync1;
        end
    end

    // Per-bit filter decision.
    // Agreement with the accepted level clears the counter, so any bounce
    // forces the whole window to be served again. Otherwise the counter
    // advances until it reaches the terminal count, and then the new level
    // is taken. Because the counter is cleared on acceptance, it stays at or
    // below TERM_CNT and never wraps.
    always_comb begin
        db_next    = chaves_db;
        mudou_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = cnt[i] + CNT_W'(1);
            if (sync2[i] == chaves_db[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == TERM_CNT) begin
                cnt_next[i]   = '0;
                db_next[i]    = sync2[i];
                mudou_next[i] = 1'b1;
            end
        end
    end

    // Register the filter state, the debounced levels and the change strobes.
    // Reset drops any count that is still in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            chaves_db    <= RESET_VAL;
            mudou        <= '0;
            alguma_mudou <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
            chaves_db    <= db_next;
            mudou        <= mudou_next;
            alguma_mudou <= |mudou_next;
        end
    end

endmodule

// File: tb/tb_debounce_chaves.sv
// tb_debounce_chaves
// Directed, table-driven bench for debounce_chaves with STABLE_CYCLES=4.
// Each table row gives the switch value driven before one rising edge and
// the outputs expected just after that edge. The reset corner cases are
// written out by hand.
module tb_debounce_chaves;

    logic       clock;
    logic       reset;
    logic [7:0] chaves;
    logic [7:0] chaves_db;
    logic [7:0] mudou;
    logic       alguma_mudou;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] sw;
        logic [7:0] db;
        logic [7:0] md;
        logic       any;
    } vec_t;

    vec_t vecs[$];

    debounce_chaves #(
        .WIDTH         (8),
        .STABLE_CYCLES (4),
        .CNT_W         (20),
        .RESET_VAL     (8'h00)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .chaves       (chaves),
        .chaves_db    (chaves_db),
        .mudou        (mudou),
        .alguma_mudou (alguma_mudou)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] sw, input logic [7:0] db,
                       input logic [7:0] md, input logic any);
        vec_t v;
        v.sw  = sw;
        v.db  = db;
        v.md  = md;
        v.any = any;
        vecs.push_back(v);
    endtask

    task automatic chk_all(input string nm, input logic [7:0] db,
                           input logic [7:0] md, input logic any);
        chk({nm, " db"}, chaves_db, db);
        chk({nm, " mudou"}, mudou, md);
        chk({nm, " alguma"}, {7'b0, alguma_mudou}, {7'b0, any});
    endtask

    initial begin
        // Reset and idle: switches at FF, accepted on edge 6 after release.
        for (int k = 1; k <= 5; k++) add(8'hFF, 8'h00, 8'h00, 1'b0);
        add(8'hFF, 8'hFF, 8'hFF, 1'b1);
        add(8'hFF, 8'hFF, 8'h00, 1'b0);
        // Return everything to 0 to set up the next case.
        for (int k = 1; k <= 5; k++) add(8'h00, 8'hFF, 8'h00, 1'b0);
        add(8'h00, 8'h00, 8'hFF, 1'b1);
        add(8'h00, 8'h00, 8'h00, 1'b0);
        // Clean change 00 -> 05.
        for (int k = 1; k <= 5; k++) add(8'h05, 8'h00, 8'h00, 1'b0);
        add(8'h05, 8'h05, 8'h05, 1'b1);
        add(8'h05, 8'h05, 8'h00, 1'b0);
        // Bounce on bit 3: 1 for 3 cycles, 0 for 1, then 1 held from edge 5.
        for (int k = 1; k <= 3; k++) add(8'h0D, 8'h05, 8'h00, 1'b0);
        add(8'h05, 8'h05, 8'h00, 1'b0);
        for (int k = 5; k <= 9; k++) add(8'h0D, 8'h05, 8'h00, 1'b0);
        add(8'h0D, 8'h0D, 8'h08, 1'b1);
        add(8'h0D, 8'h0D, 8'h00, 1'b0);
        // Threshold: bit 7 high for 4 cycles (taken), bit 6 for 3 (dropped).
        // Bit 7 then falls on edge 5, so it goes back to 0 on edge 10.
        for (int k = 1; k <= 3; k++) add(8'hCD, 8'h0D, 8'h00, 1'b0);
        add(8'h8D, 8'h0D, 8'h00, 1'b0);
        add(8'h0D, 8'h0D, 8'h00, 1'b0);
        add(8'h0D, 8'h8D, 8'h80, 1'b1);
        for (int k = 7; k <= 9; k++) add(8'h0D, 8'h8D, 8'h00, 1'b0);
        add(8'h0D, 8'h0D, 8'h80, 1'b1);
        add(8'h0D, 8'h0D, 8'h00, 1'b0);
        // Clear to 00 to set up the independent-bit case.
        for (int k = 1; k <= 5; k++) add(8'h00, 8'h0D, 8'h00, 1'b0);
        add(8'h00, 8'h00, 8'h0D, 1'b1);
        add(8'h00, 8'h00, 8'h00, 1'b0);
        // Independent bits: bit 0 rises on edge 1, bit 1 rises on edge 3.
        add(8'h01, 8'h00, 8'h00, 1'b0);
        add(8'h01, 8'h00, 8'h00, 1'b0);
        for (int k = 3; k <= 5; k++) add(8'h03, 8'h00, 8'h00, 1'b0);
        add(8'h03, 8'h01, 8'h01, 1'b1);
        add(8'h03, 8'h01, 8'h00, 1'b0);
        add(8'h03, 8'h03, 8'h02, 1'b1);
        add(8'h03, 8'h03, 8'h00, 1'b0);

        // Hold reset for a few edges while the switches read FF.
        reset  = 1'b1;
        chaves = 8'hFF;
        repeat (3) @(posedge clock);
        #1;
        chk_all("in reset", 8'h00, 8'h00, 1'b0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            chaves = vecs[i].sw;
            @(posedge clock);
            #1;
            chk_all($sformatf("row%0d", i), vecs[i].db, vecs[i].md, vecs[i].any);
        end

        // Reset during a count: bit 2 rises and reaches cnt=2 on edge 4.
        chaves = 8'h07;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock);
            #1;
            chk_all($sformatf("pre-reset e%0d", k), 8'h03, 8'h00, 1'b0);
        end
        #3;
        reset = 1'b1;
        #1;
        chk_all("async reset", 8'h00, 8'h00, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        // After release the full window has to be served again. Bits 0 and 1
        // also come back, because chaves_db was reset to 00.
        for (int k = 1; k <= 7; k++) begin
            @(posedge clock);
            #1;
            chk_all($sformatf("post-reset e%0d", k),
                    (k >= 6) ? 8'h07 : 8'h00,
                    (k == 6) ? 8'h07 : 8'h00,
                    (k == 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
